seq_det_sched: RTL and testbench

- Time-multiplexes one "1011" Mealy sequence-detect engine across NUM_CH serial bit streams.
- Each channel offers one bit per handshake. A round-robin scheduler grants one channel per cycle.
- The engine advances only the granted channel's saved detector context and reports matches tagged with the channel id.
- Sits between the per-lane bit sources and the match-event consumer.

---
 rtl/seq_det_sched.sv | 136 +++++++++++++
 tb/tb_seq_det_sched.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/seq_det_sched.sv
`default_nettype none
// ============================================================================
// Module   : seq_det_sched
// Brief    : Round-robin time-multiplexed "1011" Mealy detector over NUM_CH
//            serial bit streams; define SEQ_DET_OVERLAP_EN for overlapping
//            detection (default build is non-overlapping).
// Revision : 1.0 - initial release
// ============================================================================
module seq_det_sched #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic                      clk_i,
  input  logic                      clr_i,
  input  logic                      en_i,
  input  logic [NUM_CH-1:0]         req_valid_i,
  input  logic [NUM_CH-1:0]         req_bit_i,
  output logic [NUM_CH-1:0]         req_ready_o,
  input  logic [NUM_CH-1:0]         ch_clr_i,
  output logic                      match_o,
  output logic [$clog2(NUM_CH)-1:0] match_ch_o,
  output logic [CNT_W-1:0]          match_cnt_o,
  output logic                      busy_o
);

  localparam int              CH_W      = $clog2(NUM_CH);
  localparam logic [CH_W:0]   c_NUM     = (CH_W+1)'(NUM_CH);
  localparam logic [CH_W-1:0] c_LAST    = CH_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_R   = 2'd0,
    S_B   = 2'd1,
    S_BC  = 2'd2,
    S_BCB = 2'd3
  } ctx_t;

  ctx_t              r_ctx [NUM_CH];
  ctx_t              w_ctx_nxt [NUM_CH];
  logic [CH_W-1:0]   r_ptr;
  logic              r_match;
  logic [CH_W-1:0]   r_match_ch;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;

  logic [NUM_CH-1:0] w_elig;
  logic [NUM_CH-1:0] w_grant;
  logic [CH_W-1:0]   w_gnt_idx;
  logic              w_gnt_any;
  logic              w_match;
  logic              w_busy_nxt;
  logic [CH_W-1:0]   w_ptr_nxt;

  assign w_elig = en_i ? (req_valid_i & ~ch_clr_i) : '0;

  // First eligible channel at or above the pointer, wrapping modulo NUM_CH
  always_comb begin
    logic [CH_W:0] w_cand;
    w_grant   = '0;
    w_gnt_idx = '0;
    w_gnt_any = 1'b0;
    w_cand    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_cand = {1'b0, r_ptr} + (CH_W+1)'(i);
      if (w_cand >= c_NUM) w_cand = w_cand - c_NUM;
      if (!w_gnt_any && w_elig[w_cand[CH_W-1:0]]) begin
        w_gnt_any                     = 1'b1;
        w_gnt_idx                     = w_cand[CH_W-1:0];
        w_grant[w_cand[CH_W-1:0]]     = 1'b1;
      end
    end
  end

  assign req_ready_o = w_grant;
  assign w_ptr_nxt   = (w_gnt_idx == c_LAST) ? '0 : w_gnt_idx + CH_W'(1);

  always_comb begin
    w_ctx_nxt  = r_ctx;
    w_match    = 1'b0;
    w_busy_nxt = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_clr_i[k]) w_ctx_nxt[k] = S_R;
    end
    // A cleared channel is never granted, so the two updates cannot collide
    if (w_gnt_any) begin
      case (r_ctx[w_gnt_idx])
        S_R:   w_ctx_nxt[w_gnt_idx] = req_bit_i[w_gnt_idx] ? S_B : S_R;
        S_B:   w_ctx_nxt[w_gnt_idx] = req_bit_i[w_gnt_idx] ? S_B : S_BC;
        S_BC:  w_ctx_nxt[w_gnt_idx] = req_bit_i[w_gnt_idx] ? S_BCB : S_R;
        S_BCB: begin
          if (req_bit_i[w_gnt_idx]) begin
            w_match = 1'b1;
`ifdef SEQ_DET_OVERLAP_EN
            w_ctx_nxt[w_gnt_idx] = S_B;
`else
            w_ctx_nxt[w_gnt_idx] = S_R;
`endif
          end else begin
            w_ctx_nxt[w_gnt_idx] = S_BC;
          end
        end
        default: w_ctx_nxt[w_gnt_idx] = S_R;
      endcase
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_ctx_nxt[k] != S_R) w_busy_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      for (int k = 0; k < NUM_CH; k++) r_ctx[k] <= S_R;
      r_ptr      <= '0;
      r_match    <= 1'b0;
      r_match_ch <= '0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_ctx   <= w_ctx_nxt;
      r_match <= w_match;
      r_busy  <= w_busy_nxt;
      if (w_gnt_any) r_ptr <= w_ptr_nxt;
      if (w_match) begin
        r_match_ch <= w_gnt_idx;
        if (r_cnt != c_CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign match_o     = r_match;
  assign match_ch_o  = r_match_ch;
  assign match_cnt_o = r_cnt;
  assign busy_o      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_seq_det_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_det_sched
// Brief    : Directed self-checking bench for seq_det_sched (NUM_CH=4, CNT_W=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_det_sched;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 4;
`ifdef SEQ_DET_OVERLAP_EN
  localparam bit c_OVL = 1'b1;
`else
  localparam bit c_OVL = 1'b0;
`endif

  logic              clk_i = 1'b0;
  logic              clr_i = 1'b1;
  logic              en_i = 1'b0;
  logic [NUM_CH-1:0] req_valid_i = '0;
  logic [NUM_CH-1:0] req_bit_i = '0;
  logic [NUM_CH-1:0] req_ready_o;
  logic [NUM_CH-1:0] ch_clr_i = '0;
  logic              match_o;
  logic [1:0]        match_ch_o;
  logic [CNT_W-1:0]  match_cnt_o;
  logic              busy_o;

  int n_vec = 0;
  int n_err = 0;
  int exp_cnt = 0;
  logic [6:0] pat;
  logic [3:0] seq;

  seq_det_sched #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk_i       (clk_i),
    .clr_i       (clr_i),
    .en_i        (en_i),
    .req_valid_i (req_valid_i),
    .req_bit_i   (req_bit_i),
    .req_ready_o (req_ready_o),
    .ch_clr_i    (ch_clr_i),
    .match_o     (match_o),
    .match_ch_o  (match_ch_o),
    .match_cnt_o (match_cnt_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bump();
    if (exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
  endtask

  // One transfer on channel ch with only that channel requesting
  task automatic xfer(input int ch, input logic b);
    req_valid_i     = '0;
    req_valid_i[ch] = 1'b1;
    req_bit_i[ch]   = b;
    en_i            = 1'b1;
    #1;
    chk("grant", {28'd0, req_ready_o}, 32'(1 << ch));
    @(posedge clk_i); #1;
    req_valid_i = '0;
  endtask

  task automatic do_reset();
    clr_i = 1'b1;
    @(posedge clk_i); #1;
    clr_i = 1'b0;
    exp_cnt = 0;
  endtask

  initial begin
    // Reset values
    @(posedge clk_i); #1;
    chk("rst_match", {31'd0, match_o}, 32'd0);
    chk("rst_ch",    {30'd0, match_ch_o}, 32'd0);
    chk("rst_cnt",   {28'd0, match_cnt_o}, 32'd0);
    chk("rst_busy",  {31'd0, busy_o}, 32'd0);
    chk("rst_ready", {28'd0, req_ready_o}, 32'd0);
    clr_i = 1'b0;

    // Single channel 0: 1,0,1,1,0,1,1
    pat = 7'b1101101; // bit i is the i-th bit sent
    for (int i = 0; i < 7; i++) begin
      xfer(0, pat[i]);
      chk("t1_match", {31'd0, match_o}, {31'd0, (i == 3) || (c_OVL && i == 6)});
      if (match_o) bump();
    end
    chk("t1_ch",   {30'd0, match_ch_o}, 32'd0);
    chk("t1_cnt",  {28'd0, match_cnt_o}, c_OVL ? 32'd2 : 32'd1);
    chk("t1_busy", {31'd0, busy_o}, 32'd1);

    // Cleared channel is not granted even while valid; context returns to S_R
    req_valid_i = 4'b0001; ch_clr_i = 4'b0001; #1;
    chk("clr_noready", {28'd0, req_ready_o}, 32'd0);
    @(posedge clk_i); #1;
    ch_clr_i = '0; req_valid_i = '0;
    chk("clr_busy", {31'd0, busy_o}, 32'd0);

    // All channels valid from pointer 0, interleaved "1011"
    do_reset();
    seq = 4'b1101; // round r sends seq[r]
    en_i = 1'b1;
    req_valid_i = 4'b1111;
    for (int c = 0; c < 16; c++) begin
      req_bit_i = {4{seq[c/4]}};
      #1;
      chk("t2_grant", {28'd0, req_ready_o}, 32'(1 << (c % 4)));
      @(posedge clk_i); #1;
      chk("t2_match", {31'd0, match_o}, {31'd0, c >= 12});
      if (c >= 12) chk("t2_ch", {30'd0, match_ch_o}, 32'(c % 4));
    end
    req_valid_i = '0;
    chk("t2_cnt", {28'd0, match_cnt_o}, 32'd4);
    exp_cnt = 4;

    // ch1 partial, ch2 cleared mid-pattern while ch1 still progresses
    xfer(1, 1'b1); xfer(1, 1'b0);
    xfer(2, 1'b1); xfer(2, 1'b0); xfer(2, 1'b1);
    req_valid_i = 4'b0110; req_bit_i = 4'b0110; ch_clr_i = 4'b0100; #1;
    chk("t3_skip", {28'd0, req_ready_o}, 32'b0010);
    @(posedge clk_i); #1;
    ch_clr_i = '0; req_valid_i = '0;
    chk("t3_m0", {31'd0, match_o}, 32'd0);
    xfer(2, 1'b1);
    chk("t3_m1", {31'd0, match_o}, 32'd0);
    xfer(1, 1'b1);
    chk("t3_m_ch1", {31'd0, match_o}, 32'd1);
    chk("t3_ch1",   {30'd0, match_ch_o}, 32'd1);
    bump();
    xfer(2, 1'b0); xfer(2, 1'b1); xfer(2, 1'b1);
    chk("t3_m_ch2", {31'd0, match_o}, 32'd1);
    chk("t3_ch2",   {30'd0, match_ch_o}, 32'd2);
    bump();
    chk("t3_cnt", {28'd0, match_cnt_o}, 32'(exp_cnt));

    // ch1: 1,1,0,1,0,1,1 matches only on the 7th bit
    pat = 7'b1101011;
    for (int i = 0; i < 7; i++) begin
      xfer(1, pat[i]);
      chk("t4_match", {31'd0, match_o}, {31'd0, i == 6});
    end
    chk("t4_ch", {30'd0, match_ch_o}, 32'd1);
    bump();
    chk("t4_cnt", {28'd0, match_cnt_o}, 32'(exp_cnt));

    // Disabled scheduler: no grants, nothing changes
    req_valid_i = 4'b0001; req_bit_i = 4'b0001; en_i = 1'b0; #1;
    chk("en0_ready", {28'd0, req_ready_o}, 32'd0);
    @(posedge clk_i); #1;
    chk("en0_match", {31'd0, match_o}, 32'd0);
    chk("en0_cnt",   {28'd0, match_cnt_o}, 32'(exp_cnt));
    req_valid_i = '0; en_i = 1'b1;

    // Asynchronous clear with ch0 in S_BCB
    xfer(0, 1'b1); xfer(0, 1'b0); xfer(0, 1'b1);
    chk("t5_busy_pre", {31'd0, busy_o}, 32'd1);
    #3; clr_i = 1'b1; #1;
    chk("t5_cnt",  {28'd0, match_cnt_o}, 32'd0);
    chk("t5_ch",   {30'd0, match_ch_o}, 32'd0);
    chk("t5_busy", {31'd0, busy_o}, 32'd0);
    chk("t5_match", {31'd0, match_o}, 32'd0);
    clr_i = 1'b0; exp_cnt = 0;
    xfer(0, 1'b1);
    chk("t5_nomatch", {31'd0, match_o}, 32'd0);
    chk("t5_busy1",   {31'd0, busy_o}, 32'd1);

    // Saturation: ch0 is in S_B, finish with 0,1,1 then repeat "1011"
    xfer(0, 1'b0); xfer(0, 1'b1); xfer(0, 1'b1);
    bump();
    for (int r = 0; r < 15; r++) begin
      xfer(0, 1'b1); xfer(0, 1'b0); xfer(0, 1'b1); xfer(0, 1'b1);
      chk("t6_match", {31'd0, match_o}, 32'd1);
      bump();
    end
    chk("t6_sat", {28'd0, match_cnt_o}, 32'd15);
    chk("t6_model", {28'd0, match_cnt_o}, 32'(exp_cnt));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
